result_encoder: RTL and testbench
=================================

Name: result_encoder

Overview:
- Inverse of the input-side Data_decoder skewing: collects the column-skewed result stream leaving the MATRIX_SIZE x MATRIX_SIZE systolic array and de-skews it into full row words.
- Each row word is written back to BRAM, one row per cycle, with a BRAM write port and a completion handshake back to the controller.
- Sits between the systolic array output lanes and the result BRAM.

Parameters:
- REG_WIDTH, 16, width of one matrix element.
- MATRIX_SIZE, 4, matrix dimension N.
- BRAM_DEPTH, MATRIX_SIZE*REG_WIDTH (derived, not overridden), width of one BRAM row word.
- ADDR_WIDTH, 8, BRAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; the element at row 0, column 0 is present on col_in in the same cycle.
- col_in  in  BRAM_DEPTH  column lanes; lane c is col_in[c*REG_WIDTH +: REG_WIDTH].
- base_addr  in  ADDR_WIDTH  BRAM address for row 0; sampled on accepted start.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_WIDTH  BRAM write address.
- bram_wdata  out  BRAM_DEPTH  row word; column c sits at [c*REG_WIDTH +: REG_WIDTH].
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when all rows are written.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: bram_we=0, bram_addr=0, bram_wdata=0, busy=0, done=0, state=IDLE, cycle counter=0.
- Cycle numbering: k=0 is the cycle in which an accepted start is high.
- Input skew: lane c carries element (r,c) during cycle k=r+c, for 0<=r<N. Lane values outside that window are ignored.
- Capture window: k=0..2N-2. Row r is complete at the end of cycle k=r+N-1.
- Writes:
  - bram_we=1 during cycles k=N..2N-1, exactly N consecutive cycles.
  - Row r=k-N is written with bram_addr=base_addr+r, modulo 2^ADDR_WIDTH (wraps silently).
  - bram_wdata holds row r with column c in its lane slot.
  - bram_we=0 in all other cycles; bram_wdata/bram_addr hold their last value when bram_we=0.
- busy: high during cycles k=1..2N; low at k=2N+1.
- done: high for exactly one cycle, at k=2N.
- State machine:
  - IDLE --start--> RUN (counter cleared, base_addr latched).
  - RUN: counter increments each cycle. At counter=2N-1 --> FINISH.
  - FINISH: done=1 for one cycle, then --> IDLE.
- start rules:
  - start is accepted only in IDLE with busy=0.
  - start while busy (including during the done cycle) is ignored; the current operation is unaffected.
  - Earliest back-to-back start is k=2N+1.
- Reset mid-operation: return to IDLE next edge with all outputs at reset values; no further writes occur. Buffer contents are don't-care.
- Reset and start in the same cycle: reset wins, start is dropped.
- No arithmetic on data: elements pass through bit-exact.
- MATRIX_SIZE=1 is legal: write at k=1, done at k=2.

Decomposition:
- Shared package:
  - ARRAY_SIZE=2*MATRIX_SIZE-1 and BRAM_DEPTH localparams, shared with Data_decoder.
  - State enum {IDLE, RUN, FINISH}.
  - Lane-slice helper function.
- One sub-module: deskew_row_buffer.
  - N x N element register file written per lane at (k-c, c).
  - Provides a row-read port with bypass of the current lane input.
  - The top level holds the FSM, counter and BRAM outputs.

Test Plan:
- Basic: N=4, base_addr=8'h10, element (r,c)=16'h1000+16r+c fed skewed, start at k=0 -> writes at k=4..7:
  - addr 0x10, data 64'h1003_1002_1001_1000;
  - addr 0x13, data 64'h1033_1032_1031_1030;
  - done pulse at k=8; busy falls at k=9.
- All-ones: every lane 16'hFFFF throughout -> four writes of 64'hFFFFFFFFFFFFFFFF; lane garbage outside the capture window does not corrupt any row.
- Address wrap: base_addr=8'hFE -> addresses FE, FF, 00, 01.
- Ignored start: start re-pulsed at k=3 and k=8 -> the operation is unchanged; a start at k=9 is accepted and runs a second full sequence.
- Reset mid-op: reset at k=5 -> from the next edge bram_we, busy and done are 0 and no further writes occur. A subsequent start runs cleanly.
- Reset and start coincident in IDLE -> no operation begins; busy stays 0.

Source files
------------

// File: rtl/result_encoder_pkg.sv
// ============================================================================
// Module   : result_encoder_pkg
// Purpose  : Shared definitions for the systolic-array result path. Default
//            geometry, the derived array/row-word sizes used by the decoder
//            and encoder sides, the encoder state encoding and a lane-slice
//            helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package result_encoder_pkg;

  localparam int DEF_REG_WIDTH   = 16;
  localparam int DEF_MATRIX_SIZE = 4;

  // Skewed stream length across the array and width of one BRAM row word.
  localparam int ARRAY_SIZE = 2 * DEF_MATRIX_SIZE - 1;
  localparam int BRAM_DEPTH = DEF_MATRIX_SIZE * DEF_REG_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Low bit index of lane `lane` in a packed vector of `width`-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/result_encoder_deskew_row_buffer.sv
// ============================================================================
// Module   : deskew_row_buffer
// Purpose  : N x N element store that undoes the column skew of the array
//            output. Lane c writes element (k-c, c) during cycle k. The read
//            port returns a full row; an element arriving in the same cycle
//            it is read is taken straight from the lane input.
// Ports    : clk       - clock
//            i_cap_en  - capture enabled this cycle
//            i_k       - current cycle index k of the operation
//            i_col     - column lanes, lane c at [c*REG_WIDTH +: REG_WIDTH]
//            i_rd_row  - row to read
//            o_row     - row word, column c at [c*REG_WIDTH +: REG_WIDTH]
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module deskew_row_buffer
  import result_encoder_pkg::*;
#(
  parameter  int REG_WIDTH   = DEF_REG_WIDTH,
  parameter  int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter  int K_W         = 4,
  parameter  int ROW_IDX_W   = 2,
  localparam int DATA_W      = MATRIX_SIZE * REG_WIDTH
) (
  input  logic                 clk,
  input  logic                 i_cap_en,
  input  logic [K_W-1:0]       i_k,
  input  logic [DATA_W-1:0]    i_col,
  input  logic [ROW_IDX_W-1:0] i_rd_row,
  output logic [DATA_W-1:0]    o_row
);

  for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_col
    logic [REG_WIDTH-1:0] r_cell [MATRIX_SIZE];
    logic [REG_WIDTH-1:0] w_lane;
    logic                 w_hit;

    assign w_lane = i_col[lane_lo(c, REG_WIDTH) +: REG_WIDTH];

    // Lane c carries row r during k = r + c; values outside the window
    // never match any row and are dropped.
    always_ff @(posedge clk) begin
      if (i_cap_en) begin
        for (int r = 0; r < MATRIX_SIZE; r++) begin
          if (i_k == K_W'(r + c)) begin
            r_cell[r] <= w_lane;
          end
        end
      end
    end

    assign w_hit = ((K_W'(i_rd_row) + K_W'(c)) == i_k);
    assign o_row[lane_lo(c, REG_WIDTH) +: REG_WIDTH] = w_hit ? w_lane : r_cell[i_rd_row];
  end

endmodule

`default_nettype wire

// File: rtl/result_encoder.sv
// ============================================================================
// Module   : result_encoder
// Purpose  : De-skews the column-skewed systolic-array result stream into row
//            words and writes them to BRAM, one row per cycle, followed by a
//            one-cycle done pulse.
// Ports    : clk        - clock, rising edge
//            reset      - synchronous active-high reset
//            start      - one-cycle start; element (0,0) valid on col_in
//            col_in     - skewed column lanes
//            base_addr  - BRAM address of row 0, sampled on accepted start
//            bram_we    - BRAM write enable
//            bram_addr  - BRAM write address
//            bram_wdata - BRAM row word
//            busy       - operation in progress
//            done       - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_encoder
  import result_encoder_pkg::*;
#(
  parameter  int REG_WIDTH   = DEF_REG_WIDTH,
  parameter  int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter  int ADDR_WIDTH  = 8,
  localparam int DATA_W      = MATRIX_SIZE * REG_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     col_in,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_W-1:0]     bram_wdata,
  output logic                  busy,
  output logic                  done
);

  localparam int K_W       = $clog2(2 * MATRIX_SIZE) + 1;
  localparam int ROW_IDX_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

  localparam logic [K_W-1:0] C_K_FIRST_WR = K_W'(MATRIX_SIZE - 1);
  localparam logic [K_W-1:0] C_K_LAST_CAP = K_W'(2 * MATRIX_SIZE - 2);
  localparam logic [K_W-1:0] C_K_LAST_RUN = K_W'(2 * MATRIX_SIZE - 1);

  state_t                r_state;
  state_t                w_next;
  logic [K_W-1:0]        r_cnt;
  logic [K_W-1:0]        w_k;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] w_base;
  logic                  w_start_acc;
  logic                  w_active;
  logic                  w_wr;
  logic [ROW_IDX_W-1:0]  w_row;
  logic [DATA_W-1:0]     w_row_data;

  // Cycle k=0 is spent in IDLE (the start cycle), so the effective cycle
  // index and base address come straight from the inputs there.
  always_comb begin
    w_start_acc = start && (r_state == IDLE);
    w_active    = w_start_acc || (r_state == RUN);
    w_k         = (r_state == IDLE) ? '0 : r_cnt;
    w_base      = (r_state == IDLE) ? base_addr : r_base;
    // Row k-(N-1) completes at the end of cycle k and is presented next cycle.
    w_wr        = w_active && (w_k >= C_K_FIRST_WR) && (w_k <= C_K_LAST_CAP);
    w_row       = ROW_IDX_W'(w_k - C_K_FIRST_WR);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == C_K_LAST_RUN) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  deskew_row_buffer #(
    .REG_WIDTH   (REG_WIDTH),
    .MATRIX_SIZE (MATRIX_SIZE),
    .K_W         (K_W),
    .ROW_IDX_W   (ROW_IDX_W)
  ) u_buf (
    .clk      (clk),
    .i_cap_en (w_active),
    .i_k      (w_k),
    .i_col    (col_in),
    .i_rd_row (w_row),
    .o_row    (w_row_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_base     <= '0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt  <= K_W'(1);
            r_base <= base_addr;
          end
        end
        RUN:     r_cnt <= r_cnt + K_W'(1);
        default: r_cnt <= '0;
      endcase
      bram_we <= w_wr;
      if (w_wr) begin
        bram_addr  <= w_base + ADDR_WIDTH'(w_row);
        bram_wdata <= w_row_data;
      end
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == FINISH);

endmodule

`default_nettype wire

// File: tb/tb_result_encoder.sv
// ============================================================================
// Module   : tb_result_encoder
// Purpose  : Directed self-checking bench for result_encoder (N=4, 16-bit
//            elements, 8-bit addresses).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_result_encoder;
  import result_encoder_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [BRAM_DEPTH-1:0] col_in;
  logic [7:0]            base_addr;
  logic                  bram_we;
  logic [7:0]            bram_addr;
  logic [BRAM_DEPTH-1:0] bram_wdata;
  logic                  busy;
  logic                  done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  result_encoder #(
    .REG_WIDTH   (16),
    .MATRIX_SIZE (4),
    .ADDR_WIDTH  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .col_in     (col_in),
    .base_addr  (base_addr),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance to 1ns after the next rising edge: start of a new cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected row words, element (r,c) = 16'h1000 + 16*r + c.
  function automatic logic [63:0] row_word(input int r, input bit ones);
    if (ones) return 64'hFFFF_FFFF_FFFF_FFFF;
    case (r)
      0:       return 64'h1003_1002_1001_1000;
      1:       return 64'h1013_1012_1011_1010;
      2:       return 64'h1023_1022_1021_1020;
      default: return 64'h1033_1032_1031_1030;
    endcase
  endfunction

  // Skewed lane drive for cycle k; random garbage outside the valid window.
  task automatic drive(input int k, input bit ones);
    for (int c = 0; c < 4; c++) begin
      int r;
      r = k - c;
      if (ones)
        col_in[c*16 +: 16] = 16'hFFFF;
      else if (r >= 0 && r < 4)
        col_in[c*16 +: 16] = 16'(32'h1000 + 16 * r + c);
      else
        col_in[c*16 +: 16] = 16'($urandom);
    end
  endtask

  // One operation, cycles k=0..8. extra_start marks cycles with a start
  // pulse that must be ignored; base_addr is scrambled after k=0.
  task automatic std_op(input string tag, input logic [7:0] base, input bit ones,
                        input logic [8:0] extra_start);
    for (int k = 0; k <= 8; k++) begin
      cyc();
      start     = (k == 0) || extra_start[k];
      base_addr = (k == 0) ? base : 8'h55;
      drive(k, ones);
      if (k == 0) begin
        chk($sformatf("%s k0 we", tag), 64'(bram_we), 64'd0);
        chk($sformatf("%s k0 busy", tag), 64'(busy), 64'd0);
        chk($sformatf("%s k0 done", tag), 64'(done), 64'd0);
      end else if (k <= 3) begin
        chk($sformatf("%s k%0d we", tag, k), 64'(bram_we), 64'd0);
        chk($sformatf("%s k%0d busy", tag, k), 64'(busy), 64'd1);
      end else if (k <= 7) begin
        chk($sformatf("%s k%0d we", tag, k), 64'(bram_we), 64'd1);
        chk($sformatf("%s k%0d addr", tag, k), 64'(bram_addr), 64'(8'(base + 8'(k - 4))));
        chk($sformatf("%s k%0d data", tag, k), bram_wdata, row_word(k - 4, ones));
        chk($sformatf("%s k%0d done", tag, k), 64'(done), 64'd0);
      end else begin
        chk($sformatf("%s k8 we", tag), 64'(bram_we), 64'd0);
        chk($sformatf("%s k8 done", tag), 64'(done), 64'd1);
        chk($sformatf("%s k8 busy", tag), 64'(busy), 64'd1);
        chk($sformatf("%s k8 addr hold", tag), 64'(bram_addr), 64'(8'(base + 8'd3)));
        chk($sformatf("%s k8 data hold", tag), bram_wdata, row_word(3, ones));
      end
    end
  endtask

  task automatic idle_chk(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      start  = 1'b0;
      col_in = {$urandom, $urandom};
      chk($sformatf("%s idle%0d we", tag, i), 64'(bram_we), 64'd0);
      chk($sformatf("%s idle%0d busy", tag, i), 64'(busy), 64'd0);
      chk($sformatf("%s idle%0d done", tag, i), 64'(done), 64'd0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    col_in    = '0;
    base_addr = 8'h00;
    repeat (3) cyc();
    chk("reset we", 64'(bram_we), 64'd0);
    chk("reset addr", 64'(bram_addr), 64'd0);
    chk("reset data", bram_wdata, 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    reset = 1'b0;

    std_op("basic", 8'h10, 1'b0, 9'd0);
    idle_chk("basic_end", 1);

    std_op("ones", 8'h00, 1'b1, 9'd0);
    idle_chk("ones_end", 1);

    std_op("wrap", 8'hFE, 1'b0, 9'd0);
    idle_chk("wrap_end", 1);

    // Starts at k=3 and k=8 ignored; start at k=9 begins a second operation.
    std_op("ignore", 8'h20, 1'b0, 9'b1_0000_1000);
    std_op("b2b", 8'h30, 1'b0, 9'd0);
    idle_chk("b2b_end", 1);

    // Reset asserted during k=5.
    for (int k = 0; k <= 5; k++) begin
      cyc();
      start     = (k == 0);
      base_addr = 8'h40;
      reset     = (k == 5);
      drive(k, 1'b0);
      if (k == 4) begin
        chk("rst k4 we", 64'(bram_we), 64'd1);
        chk("rst k4 addr", 64'(bram_addr), 64'h40);
        chk("rst k4 data", bram_wdata, 64'h1003_1002_1001_1000);
      end
      if (k == 5) begin
        chk("rst k5 we", 64'(bram_we), 64'd1);
        chk("rst k5 addr", 64'(bram_addr), 64'h41);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      reset  = 1'b0;
      start  = 1'b0;
      col_in = {$urandom, $urandom};
      chk($sformatf("rst post%0d we", i), 64'(bram_we), 64'd0);
      chk($sformatf("rst post%0d addr", i), 64'(bram_addr), 64'd0);
      chk($sformatf("rst post%0d data", i), bram_wdata, 64'd0);
      chk($sformatf("rst post%0d busy", i), 64'(busy), 64'd0);
      chk($sformatf("rst post%0d done", i), 64'(done), 64'd0);
    end
    std_op("after_rst", 8'h50, 1'b0, 9'd0);
    idle_chk("after_rst_end", 1);

    // Reset and start together: start dropped.
    cyc();
    reset     = 1'b1;
    start     = 1'b1;
    base_addr = 8'h77;
    drive(0, 1'b0);
    cyc();
    reset = 1'b0;
    start = 1'b0;
    chk("coinc busy", 64'(busy), 64'd0);
    idle_chk("coinc", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
